alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu_if.sv | 17 +
 rtl/alu_mdu.sv | 184 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between a requester and alu_mdu
interface alu_mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            cond_chk;
    logic            illegal;
    modport master (output start, op, src_a, src_b, flush, input busy, done, result, cond_chk, illegal);
    modport slave (input start, op, src_a, src_b, flush, output busy, done, result, cond_chk, illegal);
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative shift-add multiplier; divider built only with ALU_MDU_DIV_EN
module alu_mdu #(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      reset,
    alu_mdu_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);
`ifdef ALU_MDU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
`endif
    state_t state, state_nx;
    logic [SW-1:0] cnt, cnt_nx, sh;
    logic [2*XLEN-1:0] acc, acc_nx, mul_nx, prod;
    logic [XLEN-1:0] a, b, alu_res, mcand, mcand_nx, result, result_nx;
    logic [XLEN:0] sum;
    logic [4:0] op;
    logic [1:0] op_r, op_r_nx;
    logic neg, neg_nx, busy, busy_nx, done, done_nx, cond_chk, cond_nx, illegal, illegal_nx;
    logic lt, ltu, cond, is_cmp, ma_neg, mb_neg;
    assign a = bus.src_a;
    assign b = bus.src_b;
    assign op = bus.op;
    assign sh = b[SW-1:0];
    assign lt = $signed(a) < $signed(b);
    assign ltu = a < b;
    assign cond = op[2:1] == 2'b01 ? (a == b) ^ op[0] : op[2:1] == 2'b10 ? lt ^ op[0] : ltu ^ op[0];
    assign is_cmp = ~op[4] & op[3] & (op[2] | op[1]);
    // MULH and MULHSU take A as signed, only MULH takes B as signed; magnitudes multiplied, sign fixed at the end
    assign ma_neg = a[XLEN-1] & (op[1] ^ op[0]);
    assign mb_neg = b[XLEN-1] & ~op[1] & op[0];
    assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_nx = {sum, acc[XLEN-1:1]};
    assign prod = neg ? -mul_nx : mul_nx;
`ifdef ALU_MDU_DIV_EN
    // restoring divider: acc holds {partial remainder, dividend shifting into quotient}
    logic [XLEN:0] sft;
    logic [XLEN-1:0] diff, dv_res;
    logic [2*XLEN-1:0] div_nx;
    logic ge, da_neg, db_neg, div0, ovf;
    assign sft = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign ge = sft >= {1'b0, mcand};
    assign diff = sft[XLEN-1:0] - mcand;
    assign div_nx = {ge ? diff : sft[XLEN-1:0], acc[XLEN-2:0], ge};
    assign dv_res = op_r[1] ? div_nx[2*XLEN-1:XLEN] : div_nx[XLEN-1:0];
    assign da_neg = ~op[0] & a[XLEN-1];
    assign db_neg = ~op[0] & b[XLEN-1];
    assign div0 = b == '0;
    assign ovf = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
`endif
    // single-cycle operation results
    always_comb begin
        case (op[3:0])
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a & b;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = a ^ b;
            4'd5:    alu_res = a << sh;
            4'd6:    alu_res = a >> sh;
            4'd7:    alu_res = $signed(a) >>> sh;
            4'd8:    alu_res = XLEN'(lt);
            4'd9:    alu_res = XLEN'(ltu);
            default: alu_res = XLEN'(cond);
        endcase
    end
    // next state, iteration step and registered-output values
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        acc_nx = acc;
        mcand_nx = mcand;
        neg_nx = neg;
        op_r_nx = op_r;
        busy_nx = busy;
        done_nx = 1'b0;
        result_nx = result;
        cond_nx = cond_chk;
        illegal_nx = 1'b0;
        if (bus.flush) begin
            state_nx = IDLE;
            busy_nx = 1'b0;
            cnt_nx = '0;
        end else if (state == MUL) begin
            acc_nx = mul_nx;
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) begin
                state_nx = FIN;
                busy_nx = 1'b0;
                done_nx = 1'b1;
                cnt_nx = '0;
                result_nx = op_r == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                cond_nx = 1'b0;
            end
`ifdef ALU_MDU_DIV_EN
        end else if (state == DIV) begin
            acc_nx = div_nx;
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) begin
                state_nx = FIN;
                busy_nx = 1'b0;
                done_nx = 1'b1;
                cnt_nx = '0;
                result_nx = neg ? -dv_res : dv_res;
                cond_nx = 1'b0;
            end
`endif
        end else begin
            state_nx = IDLE;
            if (bus.start) begin
                op_r_nx = op[1:0];
                cnt_nx = '0;
                if (!op[4]) begin
                    state_nx = FIN;
                    done_nx = 1'b1;
                    result_nx = alu_res;
                    cond_nx = is_cmp & cond;
                end else if (op[3:2] == 2'b00) begin
                    state_nx = MUL;
                    busy_nx = 1'b1;
                    acc_nx = {{XLEN{1'b0}}, mb_neg ? -b : b};
                    mcand_nx = ma_neg ? -a : a;
                    neg_nx = ma_neg ^ mb_neg;
`ifdef ALU_MDU_DIV_EN
                end else if (op[3:2] == 2'b01 && (div0 || ovf)) begin
                    state_nx = FIN;
                    done_nx = 1'b1;
                    result_nx = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
                    cond_nx = 1'b0;
                end else if (op[3:2] == 2'b01) begin
                    state_nx = DIV;
                    busy_nx = 1'b1;
                    acc_nx = {{XLEN{1'b0}}, da_neg ? -a : a};
                    mcand_nx = db_neg ? -b : b;
                    neg_nx = op[1] ? da_neg : da_neg ^ db_neg;
`endif
                end else begin
                    state_nx = FIN;
                    done_nx = 1'b1;
                    result_nx = '0;
                    cond_nx = 1'b0;
                    illegal_nx = 1'b1;
                end
            end
        end
    end
    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            neg <= 1'b0;
            op_r <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            cond_chk <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            acc <= acc_nx;
            mcand <= mcand_nx;
            neg <= neg_nx;
            op_r <= op_r_nx;
            busy <= busy_nx;
            done <= done_nx;
            result <= result_nx;
            cond_chk <= cond_nx;
            illegal <= illegal_nx;
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.result = result;
    assign bus.cond_chk = cond_chk;
    assign bus.illegal = illegal;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized scoreboard bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;
    localparam int XLEN = 32;
    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        ill;
        int          lat;
        int          acc;
        logic [4:0]  op;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] last_res = '0;
    logic last_c = 1'b0;
    exp_t q[$];
    alu_mdu_if #(.XLEN(XLEN)) bus ();
    alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));
    // free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint x, y, ux, uy;
        logic [63:0] p;
        logic c;
        x = longint'($signed(a));
        y = longint'($signed(b));
        ux = longint'(a);
        uy = longint'(b);
        e.op = op;
        e.res = '0;
        e.c = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        c = 1'b0;
        p = '0;
        case (op)
            5'd0:  e.res = a + b;
            5'd1:  e.res = a - b;
            5'd2:  e.res = a & b;
            5'd3:  e.res = a | b;
            5'd4:  e.res = a ^ b;
            5'd5:  e.res = a << b[4:0];
            5'd6:  e.res = a >> b[4:0];
            5'd7:  e.res = $signed(a) >>> b[4:0];
            5'd8:  e.res = {31'b0, x < y};
            5'd9:  e.res = {31'b0, ux < uy};
            5'd10: c = a == b;
            5'd11: c = a != b;
            5'd12: c = x < y;
            5'd13: c = x >= y;
            5'd14: c = ux < uy;
            5'd15: c = ux >= uy;
            5'd16: begin p = x * y; e.res = p[31:0]; e.lat = XLEN + 1; end
            5'd17: begin p = x * y; e.res = p[63:32]; e.lat = XLEN + 1; end
            5'd18: begin p = x * uy; e.res = p[63:32]; e.lat = XLEN + 1; end
            5'd19: begin p = ux * uy; e.res = p[63:32]; e.lat = XLEN + 1; end
`ifdef ALU_MDU_DIV_EN
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (b == 0) e.res = op[1] ? a : '1;
                else if (op == 5'd20) e.res = 32'(x / y);
                else if (op == 5'd21) e.res = 32'(ux / uy);
                else if (op == 5'd22) e.res = 32'(x % y);
                else e.res = 32'(ux % uy);
                e.lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == '1)) ? 1 : XLEN + 1;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        if (op >= 5'd10 && op <= 5'd15) begin
            e.c = c;
            e.res = {31'b0, c};
        end
        return e;
    endfunction
    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.start = 1'b1;
        bus.op = op;
        bus.src_a = a;
        bus.src_b = b;
        if (!bus.busy && !bus.flush) begin
            e = model(op, a, b);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        step();
        bus.start = 1'b0;
    endtask
    task automatic do_flush();
        exp_t d;
        bus.flush = 1'b1;
        if (bus.busy) d = q.pop_back();
        issue(5'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
        bus.flush = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        q.delete();
    endtask
    // monitor: pop the scoreboard on every done, otherwise outputs must hold
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.done) begin
                if (q.size() == 0) chk("unexpected_done", 64'(bus.done), 64'd0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("op%0d_result", e.op), 64'(bus.result), 64'(e.res));
                    chk($sformatf("op%0d_cond", e.op), 64'(bus.cond_chk), 64'(e.c));
                    chk($sformatf("op%0d_illegal", e.op), 64'(bus.illegal), 64'(e.ill));
                    chk($sformatf("op%0d_latency", e.op), 64'(cyc - e.acc + 1), 64'(e.lat));
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                    last_res = e.res;
                    last_c = e.c;
                end
            end else begin
                chk("hold_result", 64'(bus.result), 64'(last_res));
                chk("hold_cond", 64'(bus.cond_chk), 64'(last_c));
                chk("illegal_idle", 64'(bus.illegal), 64'd0);
            end
        end
    end
    // directed scenarios followed by randomized traffic
    initial begin
        int r;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        #12;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_cond", 64'(bus.cond_chk), 64'd0);
        chk("reset_illegal", 64'(bus.illegal), 64'd0);
        step();
        reset = 1'b1;
        issue(5'd0, 32'h0000_1111, 32'h0000_1010);
        wait_idle();
        issue(5'd10, 32'h0000_1111, 32'h0000_1111);
        issue(5'd11, 32'h0000_1111, 32'h0000_1111);
        wait_idle();
        issue(5'd17, 32'hffff_ffff, 32'h0000_0002);
        repeat (3) step();
        chk("mul_busy", 64'(bus.busy), 64'd1);
        wait_idle();
        issue(5'd19, 32'hffff_ffff, 32'h0000_0002);
        wait_idle();
        issue(5'd16, 32'h1234_5678, 32'h9abc_def0);
        repeat (8) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_cond", 64'(bus.cond_chk), 64'd0);
        chk("arst_illegal", 64'(bus.illegal), 64'd0);
        q.delete();
        last_res = '0;
        last_c = 1'b0;
        step();
        reset = 1'b1;
        repeat (XLEN + 8) step();
        chk("arst_after_busy", 64'(bus.busy), 64'd0);
        issue(5'd0, 32'd2, 32'd3);
        wait_idle();
        issue(5'd16, 32'd7, 32'd9);
        repeat (8) step();
        do_flush();
        repeat (XLEN + 8) step();
        chk("flush_hold", 64'(bus.result), 64'd5);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        issue(5'd20, 32'hffff_fff9, 32'd2);
        wait_idle();
        issue(5'd22, 32'hffff_fff9, 32'd2);
        wait_idle();
        issue(5'd21, 32'hffff_fff9, 32'd0);
        wait_idle();
        issue(5'd20, 32'h8000_0000, 32'hffff_ffff);
        wait_idle();
        issue(5'd16, 32'd3, 32'd5);
        step();
        issue(5'd0, 32'd100, 32'd200);
        wait_idle();
        issue(5'd24, 32'd1, 32'd1);
        wait_idle();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) wait_idle();
            if (r >= 95) do_flush();
            else issue(5'($urandom_range(0, 31)), rnd_operand(), rnd_operand());
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
